// File: rtl/apb_fabric.sv
// APB fabric: one master fans out to NUM_SLAVES address-decoded slaves.
// A single transfer is in flight at a time: IDLE -> SETUP -> ACCESS -> RESP,
// or IDLE -> RESP directly on a decode miss. Errored transfers are counted
// and their address is recorded. A sticky flag records any timeout.
module apb_fabric #(
  parameter int unsigned                         ADDR_WIDTH = 32,
  parameter int unsigned                         DATA_WIDTH = 32,
  parameter int unsigned                         NUM_SLAVES = 5,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]    SLV_BASE   = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]    SLV_MASK   = '0,
  parameter int unsigned                         TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             rts_n,
  input  logic [ADDR_WIDTH-1:0]            m_paddr,
  input  logic [DATA_WIDTH-1:0]            m_pdata,
  output logic [DATA_WIDTH-1:0]            m_prdata,
  input  logic                             m_psel,
  input  logic                             m_penable,
  input  logic                             m_pwrite,
  input  logic [DATA_WIDTH/8-1:0]          m_pstb,
  output logic                             m_pready,
  output logic                             m_perr,
  output logic [ADDR_WIDTH-1:0]            s_paddr,
  output logic [DATA_WIDTH-1:0]            s_pdata,
  output logic [DATA_WIDTH/8-1:0]          s_pstb,
  output logic                             s_pwrite,
  output logic [NUM_SLAVES-1:0]            s_psel,
  output logic [NUM_SLAVES-1:0]            s_penable,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_prdata,
  input  logic [NUM_SLAVES-1:0]            s_pready,
  input  logic [NUM_SLAVES-1:0]            s_perr,
  output logic [7:0]                       err_count,
  output logic [ADDR_WIDTH-1:0]            err_addr,
  output logic                             timeout_flag
);

  localparam int unsigned StbW = DATA_WIDTH / 8;
  localparam int unsigned IdxW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [15:0] TmoVal = 16'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pdata_q, pdata_d;
  logic [StbW-1:0]         pstb_q, pstb_d;
  logic                    pwrite_q, pwrite_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [15:0]             wait_q, wait_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    perr_q, perr_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
  logic                    tmo_q, tmo_d;

  logic                    hit;
  logic [IdxW-1:0]         hit_idx;
  logic                    sel_ready;
  logic                    sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;

  // Address decode; scanning downward lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if ((m_paddr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
    end
  end

  // Pick the response of the selected slave only; all others are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (idx_q == IdxW'(i)) begin
        sel_ready = s_pready[i];
        sel_err   = s_perr[i];
        sel_rdata = s_prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state logic; response data defaults to zero so it is only non-zero in RESP.
  always_comb begin
    state_d    = state_q;
    paddr_d    = paddr_q;
    pdata_d    = pdata_q;
    pstb_d     = pstb_q;
    pwrite_d   = pwrite_q;
    idx_d      = idx_q;
    wait_d     = wait_q;
    prdata_d   = '0;
    perr_d     = 1'b0;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    tmo_d      = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (m_psel && !m_penable) begin
          paddr_d  = m_paddr;
          pdata_d  = m_pdata;
          pstb_d   = m_pstb;
          pwrite_d = m_pwrite;
          idx_d    = hit_idx;
          if (hit) begin
            state_d = StSetup;
          end else begin
            state_d = StResp;
            perr_d  = 1'b1;
          end
        end
      end
      StSetup: begin
        state_d = StAccess;
        wait_d  = '0;
      end
      StAccess: begin
        // Ready is tested first so it wins over a coincident timeout.
        if (sel_ready) begin
          state_d  = StResp;
          prdata_d = sel_rdata;
          perr_d   = sel_err;
        end else if (wait_q == TmoVal) begin
          state_d = StResp;
          perr_d  = 1'b1;
          tmo_d   = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
        if (perr_q) begin
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          err_addr_d = paddr_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rts_n) begin
      state_q    <= StIdle;
      paddr_q    <= '0;
      pdata_q    <= '0;
      pstb_q     <= '0;
      pwrite_q   <= 1'b0;
      idx_q      <= '0;
      wait_q     <= '0;
      prdata_q   <= '0;
      perr_q     <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      paddr_q    <= paddr_d;
      pdata_q    <= pdata_d;
      pstb_q     <= pstb_d;
      pwrite_q   <= pwrite_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      prdata_q   <= prdata_d;
      perr_q     <= perr_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      tmo_q      <= tmo_d;
    end
  end

  // Per-slave select/enable decoded from the registered state and index.
  always_comb begin
    s_psel    = '0;
    s_penable = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      s_psel[i]    = ((state_q == StSetup) || (state_q == StAccess)) && (idx_q == IdxW'(i));
      s_penable[i] = (state_q == StAccess) && (idx_q == IdxW'(i));
    end
  end

  assign m_pready     = (state_q == StResp);
  assign m_prdata     = prdata_q;
  assign m_perr       = perr_q;
  assign s_paddr      = paddr_q;
  assign s_pdata      = pdata_q;
  assign s_pstb       = pstb_q;
  assign s_pwrite     = pwrite_q;
  assign err_count    = err_cnt_q;
  assign err_addr     = err_addr_q;
  assign timeout_flag = tmo_q;

endmodule

// File: tb/tb_apb_fabric.sv
// Scoreboard bench for apb_fabric: a driver pushes the expected response of
// each transfer, independent monitors check the master response and the
// slave-side bus. Two slaves; unselected slaves drive noise on purpose.
module tb_apb_fabric;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 2;

  logic            clk = 1'b0;
  logic            rts_n = 1'b0;
  logic [AW-1:0]   m_paddr = '0;
  logic [DW-1:0]   m_pdata = '0;
  logic [DW-1:0]   m_prdata;
  logic            m_psel = 1'b0;
  logic            m_penable = 1'b0;
  logic            m_pwrite = 1'b0;
  logic [DW/8-1:0] m_pstb = '0;
  logic            m_pready;
  logic            m_perr;
  logic [AW-1:0]   s_paddr;
  logic [DW-1:0]   s_pdata;
  logic [DW/8-1:0] s_pstb;
  logic            s_pwrite;
  logic [NS-1:0]   s_psel;
  logic [NS-1:0]   s_penable;
  logic [NS*DW-1:0] s_prdata;
  logic [NS-1:0]   s_pready;
  logic [NS-1:0]   s_perr;
  logic [7:0]      err_count;
  logic [AW-1:0]   err_addr;
  logic            timeout_flag;

  apb_fabric #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_SLAVES (NS),
    .SLV_BASE   ({32'h8000_0000, 32'h0000_0000}),
    .SLV_MASK   ({32'hFFFF_0000, 32'hFFFF_0000}),
    .TIMEOUT    (4)
  ) dut (
    .clk          (clk),
    .rts_n        (rts_n),
    .m_paddr      (m_paddr),
    .m_pdata      (m_pdata),
    .m_prdata     (m_prdata),
    .m_psel       (m_psel),
    .m_penable    (m_penable),
    .m_pwrite     (m_pwrite),
    .m_pstb       (m_pstb),
    .m_pready     (m_pready),
    .m_perr       (m_perr),
    .s_paddr      (s_paddr),
    .s_pdata      (s_pdata),
    .s_pstb       (s_pstb),
    .s_pwrite     (s_pwrite),
    .s_psel       (s_psel),
    .s_penable    (s_penable),
    .s_prdata     (s_prdata),
    .s_pready     (s_pready),
    .s_perr       (s_perr),
    .err_count    (err_count),
    .err_addr     (err_addr),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  logic mon_en = 1'b0;

  // Expected slave-side view of the transfer in flight.
  logic [NS-1:0] exp_sel = '0;
  logic [31:0]   exp_addr = '0;
  logic [31:0]   exp_wdata = '0;
  logic [3:0]    exp_stb = '0;
  logic          exp_write = 1'b0;

  // Slave behaviour knobs.
  int          wait_cfg[NS];
  logic        never_cfg[NS];
  logic        err_cfg[NS];
  logic [31:0] rd_cfg[NS];
  int          scnt[NS];

  always @(posedge clk) cyc <= cyc + 1;

  // Slave models: selected slave answers per its knobs, others drive noise.
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      if (s_psel[i] && s_penable[i]) begin
        s_pready[i]            = !never_cfg[i] && (scnt[i] >= wait_cfg[i]);
        s_perr[i]              = err_cfg[i];
        s_prdata[i*DW +: DW]   = s_pwrite ? 32'h0 : rd_cfg[i];
      end else begin
        s_pready[i]            = 1'b1;
        s_perr[i]              = 1'b1;
        s_prdata[i*DW +: DW]   = 32'hFFFF_FFFF;
      end
    end
  end

  // Access-phase cycle counter per slave for wait-state insertion.
  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (s_psel[i] && s_penable[i]) scnt[i] <= scnt[i] + 1;
      else scnt[i] <= 0;
    end
  end

  // Response monitor: pops the scoreboard on every m_pready cycle.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (mon_en) begin
      checks++;
      if (m_pready) begin
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pready: got pready=1 prdata=%h perr=%b, required no response",
                   m_prdata, m_perr);
        end else begin
          e   = sb_q.pop_front();
          lat = cyc - start_cyc + 1;
          if (m_prdata !== e.rd || m_perr !== e.err || lat != e.lat) begin
            errors++;
            $display("FAIL %s: got prdata=%h perr=%b lat=%0d, required prdata=%h perr=%b lat=%0d",
                     e.name, m_prdata, m_perr, lat, e.rd, e.err, e.lat);
          end
        end
      end else if (m_prdata !== 32'h0 || m_perr !== 1'b0) begin
        errors++;
        $display("FAIL idle_resp_zero: got prdata=%h perr=%b, required 0 0", m_prdata, m_perr);
      end
    end
  end

  // Slave-side monitor: select, enable sequencing and held broadcast values.
  logic [NS-1:0] prev_sel = '0;
  always @(negedge clk) begin
    if (mon_en && rts_n && (|s_psel)) begin
      checks++;
      if (s_psel !== exp_sel || s_paddr !== exp_addr || s_pdata !== exp_wdata ||
          s_pstb !== exp_stb || s_pwrite !== exp_write ||
          (prev_sel == '0 && s_penable != '0) ||
          (prev_sel != '0 && s_penable !== s_psel)) begin
        errors++;
        $display({"FAIL slave_bus: got sel=%b en=%b addr=%h data=%h stb=%b wr=%b, ",
                  "required sel=%b addr=%h data=%h stb=%b wr=%b"},
                 s_psel, s_penable, s_paddr, s_pdata, s_pstb, s_pwrite,
                 exp_sel, exp_addr, exp_wdata, exp_stb, exp_write);
      end
    end
    prev_sel <= s_psel;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Issues one transfer; leaves the bus in the cycle after RESP so another
  // call can follow back-to-back.
  task automatic xfer(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic wr, input logic [3:0] stb, input logic [NS-1:0] sel,
                      input logic [31:0] erd, input logic eerr, input int elat);
    exp_t e;
    int   n;
    e.rd = erd; e.err = eerr; e.lat = elat; e.name = name;
    sb_q.push_back(e);
    exp_sel = sel; exp_addr = addr; exp_wdata = wdata; exp_stb = stb; exp_write = wr;
    m_paddr = addr; m_pdata = wdata; m_pwrite = wr; m_pstb = stb;
    m_psel = 1'b1; m_penable = 1'b0;
    start_cyc = cyc;
    @(posedge clk); #1;
    m_penable = 1'b1;
    n = 0;
    while (!m_pready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!m_pready) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no pready in 100 cycles, required a response", name);
      sb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    m_psel = 1'b0;
    m_penable = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NS; i++) begin
      wait_cfg[i] = 0; never_cfg[i] = 1'b0; err_cfg[i] = 1'b0; scnt[i] = 0;
    end
    rd_cfg[0] = 32'h1234_5678;
    rd_cfg[1] = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", 64'(m_pready), 64'h0);
    chk("rst_prdata", 64'(m_prdata), 64'h0);
    chk("rst_perr", 64'(m_perr), 64'h0);
    chk("rst_psel", 64'({s_psel, s_penable}), 64'h0);
    chk("rst_bcast", 64'({s_paddr, s_pstb, s_pwrite}), 64'h0);
    chk("rst_err_count", 64'(err_count), 64'h0);
    chk("rst_err_addr", 64'(err_addr), 64'h0);
    chk("rst_timeout_flag", 64'(timeout_flag), 64'h0);
    rts_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Zero-wait read from slave 1.
    xfer("read_s1", 32'h8000_0010, 32'h0, 1'b0, 4'hF, 2'b10, 32'hDEAD_BEEF, 1'b0, 4);
    // Write to slave 0 with three wait states, back-to-back.
    wait_cfg[0] = 3;
    xfer("write_s0_wait3", 32'h0000_0010, 32'hA5A5_0F0F, 1'b1, 4'b0011, 2'b01, 32'h0, 1'b0, 7);
    wait_cfg[0] = 0;
    xfer("read_s0_b2b", 32'h0000_0014, 32'h0, 1'b0, 4'hF, 2'b01, 32'h1234_5678, 1'b0, 4);
    // Decode miss.
    xfer("miss", 32'h4000_0000, 32'h0, 1'b0, 4'hF, 2'b00, 32'h0, 1'b1, 2);
    idle();
    chk("miss_err_count", 64'(err_count), 64'd1);
    chk("miss_err_addr", 64'(err_addr), 64'h4000_0000);
    // Slave error: data still returned, perr set.
    err_cfg[1] = 1'b1;
    xfer("slv_err", 32'h8000_0020, 32'h0, 1'b0, 4'hF, 2'b10, 32'hDEAD_BEEF, 1'b1, 4);
    err_cfg[1] = 1'b0;
    idle();
    chk("slverr_err_count", 64'(err_count), 64'd2);
    chk("slverr_err_addr", 64'(err_addr), 64'h8000_0020);
    chk("pre_tmo_flag", 64'(timeout_flag), 64'h0);
    // Timeout: slave 0 never ready.
    never_cfg[0] = 1'b1;
    xfer("timeout", 32'h0000_0020, 32'h5555_AAAA, 1'b1, 4'hF, 2'b01, 32'h0, 1'b1, 8);
    never_cfg[0] = 1'b0;
    idle();
    chk("tmo_flag", 64'(timeout_flag), 64'h1);
    chk("tmo_err_count", 64'(err_count), 64'd3);
    xfer("good_after_tmo", 32'h8000_0000, 32'h0, 1'b0, 4'hF, 2'b10, 32'hDEAD_BEEF, 1'b0, 4);
    idle();
    chk("tmo_flag_sticky", 64'(timeout_flag), 64'h1);

    // Reset in the middle of ACCESS abandons the transfer.
    never_cfg[0] = 1'b1;
    exp_sel = 2'b01; exp_addr = 32'h30; exp_wdata = 32'h0; exp_stb = 4'hF; exp_write = 1'b0;
    m_paddr = 32'h30; m_pdata = 32'h0; m_pwrite = 1'b0; m_pstb = 4'hF;
    m_psel = 1'b1; m_penable = 1'b0;
    @(posedge clk); #1;
    m_penable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_in_access", 64'(s_penable), 64'h1);
    rts_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_psel", 64'({s_psel, s_penable}), 64'h0);
    chk("abort_pready", 64'(m_pready), 64'h0);
    chk("abort_err_count", 64'(err_count), 64'h0);
    chk("abort_err_addr", 64'(err_addr), 64'h0);
    chk("abort_tmo_flag", 64'(timeout_flag), 64'h0);
    rts_n = 1'b1;
    idle();
    never_cfg[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    xfer("after_reset", 32'h8000_0004, 32'h0, 1'b0, 4'hF, 2'b10, 32'hDEAD_BEEF, 1'b0, 4);

    // Error counter saturation over 300 errored transfers.
    err_cfg[1] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      xfer("sat_err", 32'h8000_0008, 32'h0, 1'b0, 4'hF, 2'b10, 32'hDEAD_BEEF, 1'b1, 4);
      if (i == 253) chk("err_count_254", 64'(err_count), 64'd254);
      if (i == 254) chk("err_count_255", 64'(err_count), 64'd255);
    end
    err_cfg[1] = 1'b0;
    idle();
    chk("err_count_sat", 64'(err_count), 64'd255);
    chk("sat_err_addr", 64'(err_addr), 64'h8000_0008);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
